// File: rtl/acc_master_pkg.sv
// rtl/acc_master_pkg.sv - shared types and defaults for the Avalon-MM accumulating master
package acc_master_pkg;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LEN_W        = 15;
  localparam int DEF_READ_LATENCY = 1;
  // Latency counter width covers READ_LATENCY values 1..4.
  localparam int LAT_W            = 3;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/acc_master_adder.sv
// rtl/acc_master_adder.sv - combinational accumulator adder with carry-out; ACC_SATURATE_EN clamps to all-ones
module acc_master_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  logic [DATA_W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o  = full_sum[DATA_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero addend carries again, so the sum stays saturated.
  assign sum_o = full_sum[DATA_W] ? {DATA_W{1'b1}} : full_sum[DATA_W-1:0];
`else
  assign sum_o = full_sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/acc_avalon_master.sv
// rtl/acc_avalon_master.sv - Avalon-MM master summing a word block and writing the sum back; ACC_SATURATE_EN selects saturating add
module acc_avalon_master
  import acc_master_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;

  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_carry;

  acc_master_adder #(.DATA_W(DATA_W)) u_adder (
    .a_i     (acc_q),
    .b_i     (m_readdata),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (!m_waitrequest) begin
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          lat_d   = LAT_W'(READ_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        // Read data is valid in the cycle the counter expires.
        if (lat_q == LAT_W'(1)) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          state_d = (rem_q == '0) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          result_d = acc_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they change only on clk edges.
  always_comb begin
    read_d  = (state_d == ST_READ);
    write_d = (state_d == ST_WRITE);
    addr_d  = read_d ? ptr_d : (write_d ? dst_d : '0);
    wdata_d = write_d ? acc_d : '0;
    be_d    = (read_d || write_d) ? BE_ALL : 4'h0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      lat_q    <= lat_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign ovf          = ovf_q;
  assign m_address    = addr_q;
  assign m_read       = read_q;
  assign m_write      = write_q;
  assign m_chipselect = read_q | write_q;
  assign m_byteenable = be_q;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_acc_avalon_master.sv
// tb/tb_acc_avalon_master.sv - directed table-driven bench for acc_avalon_master
module tb_acc_avalon_master;

  localparam int LAT = 1;

  typedef struct {
    logic [13:0]      src;
    logic [13:0]      dst;
    logic [14:0]      len;
    logic [3:0][31:0] words;
    int               stall_idx;
    int               stall_len;
    logic [31:0]      exp_result;
    logic             exp_ovf;
    int               exp_wr_off;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [13:0] src_addr;
  logic [13:0] dst_addr;
  logic [14:0] len;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic [13:0] m_address;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  logic [31:0] mem [0:16383];
  int          cyc;
  logic        clr_log;
  int          stall_idx;
  int          stall_len;

  logic [13:0] rd_q[$];
  int          rd_cnt;
  int          stall_cnt;
  bit          wr_seen, done_seen, inv_err, hold_err, hold_v, busy_at_done;
  logic [13:0] wr_addr, hold_addr;
  logic [31:0] wr_data;
  int          wr_cyc, done_cyc;

  int n_cmp;
  int n_bad;

  acc_avalon_master #(
    .ADDR_W(14), .DATA_W(32), .LEN_W(15), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    m_readdata <= (m_read && !m_waitrequest) ? mem[m_address] : 32'hDEADBEEF;
  end

  // Slave model and bus monitor: decides waitrequest for the next edge and logs accepted requests.
  always @(negedge clk) begin
    if (clr_log) begin
      rd_q.delete();
      rd_cnt = 0; stall_cnt = 0;
      wr_seen = 0; done_seen = 0; inv_err = 0; hold_err = 0; hold_v = 0; busy_at_done = 0;
      wr_addr = '0; wr_data = '0; wr_cyc = 0; done_cyc = 0;
      m_waitrequest = 1'b0;
    end else begin
      if (m_read && m_write) inv_err = 1;
      if (m_chipselect != (m_read | m_write)) inv_err = 1;
      if (m_byteenable != ((m_read | m_write) ? 4'hF : 4'h0)) inv_err = 1;
      if (hold_v && (!m_read || m_address != hold_addr)) hold_err = 1;
      hold_v = 0;
      if (m_read && rd_cnt == stall_idx && stall_cnt < stall_len) begin
        m_waitrequest = 1'b1;
        stall_cnt++;
        hold_v = 1;
        hold_addr = m_address;
      end else begin
        m_waitrequest = 1'b0;
      end
      if (m_read && !m_waitrequest) begin
        rd_q.push_back(m_address);
        rd_cnt++;
      end
      if (m_write && !m_waitrequest && !wr_seen) begin
        wr_seen = 1; wr_addr = m_address; wr_data = m_writedata; wr_cyc = cyc;
      end
      if (done && !done_seen) begin
        done_seen = 1; done_cyc = cyc; busy_at_done = busy;
      end
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    logic [13:0] a;
    for (int i = 0; i < 4; i++) begin
      a = v.src + 14'(i);
      mem[a] = v.words[i];
    end
  endtask

  task automatic launch(input vec_t v, output int k);
    load_mem(v);
    @(posedge clk); #1;
    clr_log = 1'b1; stall_idx = v.stall_idx; stall_len = v.stall_len;
    @(negedge clk); #1;
    clr_log = 1'b0;
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic finish(input vec_t v, input int k, input string nm);
    int t;
    logic [13:0] ea;
    t = 0;
    while (!done_seen && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    check({nm, "_done_seen"}, done_seen, 1'b1);
    check({nm, "_nreads"}, rd_q.size(), v.len);
    for (int i = 0; i < int'(v.len) && i < rd_q.size(); i++) begin
      ea = v.src + 14'(i);
      check($sformatf("%s_rd%0d_addr", nm, i), rd_q[i], ea);
    end
    check({nm, "_wr_addr"}, wr_addr, v.dst);
    check({nm, "_wr_data"}, wr_data, v.exp_result);
    check({nm, "_wr_off"}, wr_cyc - k, v.exp_wr_off);
    check({nm, "_done_off"}, done_cyc - k, v.exp_wr_off + 1);
    check({nm, "_result"}, result, v.exp_result);
    check({nm, "_ovf"}, ovf, v.exp_ovf);
    check({nm, "_busy_at_done"}, busy_at_done, 1'b1);
    check({nm, "_bus_rules"}, {inv_err, hold_err}, 2'b00);
    @(negedge clk); #1;
    check({nm, "_idle_after"}, {busy, done, m_read, m_write}, 4'b0000);
    check({nm, "_result_held"}, {result, ovf}, {v.exp_result, v.exp_ovf});
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k;
    launch(v, k);
    finish(v, k, nm);
  endtask

  vec_t vecs[7];
  vec_t vb;
  int   kk;
  int   t;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    clr_log = 1'b1; stall_idx = -1; stall_len = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

    vecs[0] = '{14'h0010, 14'h0100, 15'd4, {32'd4, 32'd3, 32'd2, 32'd1}, -1, 0, 32'd10, 1'b0, 8};
    vecs[1] = '{14'h0010, 14'h0100, 15'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 1, 3, 32'd10, 1'b0, 11};
`ifdef ACC_SATURATE_EN
    vecs[2] = '{14'h0020, 14'h0030, 15'd2, {32'd0, 32'd0, 32'h2, 32'hFFFFFFFF}, -1, 0, 32'hFFFFFFFF, 1'b1, 4};
    vecs[5] = '{14'h0040, 14'h0031, 15'd3, {32'd0, 32'h80000000, 32'h80000000, 32'h80000000}, 2, 1, 32'hFFFFFFFF, 1'b1, 7};
`else
    vecs[2] = '{14'h0020, 14'h0030, 15'd2, {32'd0, 32'd0, 32'h2, 32'hFFFFFFFF}, -1, 0, 32'h00000001, 1'b1, 4};
    vecs[5] = '{14'h0040, 14'h0031, 15'd3, {32'd0, 32'h80000000, 32'h80000000, 32'h80000000}, 2, 1, 32'h80000000, 1'b1, 7};
`endif
    vecs[3] = '{14'h0000, 14'h0005, 15'd0, {32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 32'd0, 1'b0, 0};
    vecs[4] = '{14'h3FFE, 14'h0200, 15'd4, {32'd8, 32'd7, 32'd6, 32'd5}, -1, 0, 32'd26, 1'b0, 8};
    vecs[6] = '{14'h0050, 14'h0051, 15'd1, {32'd0, 32'd0, 32'd0, 32'd7}, -1, 0, 32'd7, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, result, ovf}, 35'd0);
    check("reset_bus", {m_address, m_chipselect, m_read, m_write, m_byteenable, m_writedata}, 53'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    clr_log = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulse while busy must not disturb the run in flight.
    launch(vecs[0], kk);
    repeat (3) @(negedge clk);
    #1;
    src_addr = 14'h3FFE; dst_addr = 14'h0005; len = 15'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish(vecs[0], kk, "start_busy");

    // Asynchronous reset during the third read of a 4-word run.
    launch(vecs[0], kk);
    t = 0;
    while (!(m_read && rd_cnt == 3) && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check("midreset_reached_read3", {m_read, 32'(rd_cnt)}, {1'b1, 32'd3});
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", {busy, done, result, ovf}, 35'd0);
    check("midreset_bus", {m_address, m_chipselect, m_read, m_write, m_byteenable, m_writedata}, 53'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    vb = vecs[1];
    run_vec(vb, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_avalon_master.md
# acc_avalon_master

Avalon-MM initiator that sums a block of 32-bit words from the on-chip data memory and writes the sum back to it. It is the master end of the single-port RAM's slave interface (14-bit word address, 4-bit byteenable, 32-bit data, fixed read latency). It sits between the system interconnect and a small control register interface, so the NIOS software launches a hardware accumulation without a CPU load/add loop.

## Interface
Parameters:
- ADDR_W, 14, word-address width (16384 words)
- DATA_W, 32, data and accumulator width
- LEN_W, 15, word-count width (0..16384)
- READ_LATENCY, 1, cycles from accepted read to valid `m_readdata` (1..4)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  result word address
- len  in  LEN_W  number of words to sum
- busy  out  1  high from the cycle after an accepted start until `done`, inclusive
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  final sum; held until the next accepted start
- ovf  out  1  sticky carry-out of any addition this run; cleared on start
- m_address  out  ADDR_W  word address
- m_chipselect  out  1  high whenever `m_read` or `m_write` is high
- m_read  out  1  read request
- m_write  out  1  write request
- m_byteenable  out  4  always 4'hF during requests, 4'h0 otherwise
- m_writedata  out  DATA_W  write data
- m_readdata  in  DATA_W  read data
- m_waitrequest  in  1  slave or interconnect stall; a request is held unchanged while high

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: on `start` latch src_addr, dst_addr and len; clear acc and ovf; go to READ, or to WRITE if len==0.
- READ: drive `m_read`=1 and `m_address`=current pointer. On `~m_waitrequest` the request is accepted: increment the pointer modulo 2^ADDR_W, decrement the remaining count, load the latency counter with READ_LATENCY, go to WAIT.
- WAIT: decrement the latency counter. On the edge where it reaches 0, set acc <= acc + m_readdata and ovf |= carry. Go to READ if words remain, else WRITE.
- WRITE: drive `m_write`=1, `m_address`=dst_addr, `m_writedata`=acc. On `~m_waitrequest` copy acc to `result` and go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, with no queuing.
- len==0: no reads are issued; 0 is written to dst_addr and ovf=0.
- Source ranges crossing 16383 wrap to 0. dst_addr may lie inside the source range; the write always follows the final read.
- Only one transaction is outstanding at a time. `m_read` and `m_write` are never high together.

## Timing
- Reset value of every output is 0, including `m_byteenable`=4'h0. Reset takes effect immediately, even mid-transaction: requests drop and the FSM returns to IDLE.
- Per word with no stalls: 1 + READ_LATENCY cycles. Each waitrequest cycle adds 1.
- With `start` high at edge k, `m_read` is first asserted in cycle k+1. With no stalls, `m_write` is asserted in cycle k+1+len*(1+READ_LATENCY) and `done` one cycle later.
- `result` and `ovf` are valid in the `done` cycle and stay stable afterwards.
- Request outputs are registered and change only on clk edges.

## Configuration
- ACC_SATURATE_EN defined: unsigned saturating add. On carry, acc becomes all-ones and stays saturated; ovf is still set.
- ACC_SATURATE_EN undefined: modulo 2^DATA_W add; ovf flags any wrap.

## Structure
- Package `acc_master_pkg`: state enum, ADDR_W/DATA_W/LEN_W defaults, BE_ALL=4'hF.
- One sub-module, `acc_master_adder`: combinational DATA_W adder returning sum and carry, with the saturation option inside it.

## Test plan
- Memory 0x0010..0x0013 = 1,2,3,4; len=4; dst=0x0100; L=1; start at edge k -> reads of 0x10..0x13; write of 10 to 0x0100 in cycle k+9; done in cycle k+10; ovf=0.
- Same run with waitrequest high for 3 cycles on the second read -> address held stable; done at k+13; result=10.
- len=0, dst=0x0005 -> no m_read; write of 0 to 0x0005 at k+1; done at k+2.
- src=0x3FFE, len=4 -> read addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Words 0xFFFFFFFF, 0x00000002 -> result 0xFFFFFFFF with ACC_SATURATE_EN, else 0x00000001; ovf=1 in both builds.
- reset_n low during the third read of a 4-word run -> all outputs 0 immediately; a later start runs cleanly. A start pulse while busy -> no effect on the run.
